// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the two-requester ALU arbiter.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_lhs;
    logic [31:0] req0_rhs;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_lhs;
    logic [31:0] req1_rhs;
    logic [3:0]  alu_op;
    logic [31:0] alu_lhs;
    logic [31:0] alu_rhs;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;
    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_res;
    logic [3:0]  resp_flags;
    logic        resp_err;
    logic        resp_ready;

    // Arbiter view
    modport slave (
        input  req0_valid, req0_op, req0_lhs, req0_rhs,
        input  req1_valid, req1_op, req1_lhs, req1_rhs,
        output req0_ready, req1_ready,
        output alu_op, alu_lhs, alu_rhs,
        input  alu_res, alu_flags,
        output resp_valid, resp_id, resp_res, resp_flags, resp_err,
        input  resp_ready
    );

    // Requester / ALU / consumer view
    modport master (
        output req0_valid, req0_op, req0_lhs, req0_rhs,
        output req1_valid, req1_op, req1_lhs, req1_rhs,
        input  req0_ready, req1_ready,
        input  alu_op, alu_lhs, alu_rhs,
        output alu_res, alu_flags,
        input  resp_valid, resp_id, resp_res, resp_flags, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// One operation in flight: accept in IDLE, one EXEC cycle, hold response in RESP.
module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        id_q;
    logic [3:0]  op_q;
    logic [31:0] lhs_q;
    logic [31:0] rhs_q;
    logic [31:0] res_q;
    logic [3:0]  flags_q;
    logic        err_q;

    logic        grant_valid;
    logic        grant_id;
    logic        accept;
    logic [3:0]  sel_op;
    logic [31:0] sel_lhs;
    logic [31:0] sel_rhs;
    logic        sel_illegal;

    // Pick a winner among valid requesters and mux its operation
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = 1'b0;
        if (FIXED_PRIO) begin
            grant_id = ~bus.req0_valid;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = ~bus.req0_valid;
        end
        // rst_n gating keeps ready low for the whole reset pulse
        accept      = (state_q == StIdle) && grant_valid && rst_n;
        sel_op      = grant_id ? bus.req1_op  : bus.req0_op;
        sel_lhs     = grant_id ? bus.req1_lhs : bus.req0_lhs;
        sel_rhs     = grant_id ? bus.req1_rhs : bus.req0_rhs;
        sel_illegal = (sel_op > 4'hB);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; illegal opcodes skip EXEC
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = sel_illegal ? StResp : StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: grant strobes, response bus, operand registers to the ALU
    always_comb begin
        bus.req0_ready = accept && !grant_id;
        bus.req1_ready = accept && grant_id;
        bus.resp_valid = (state_q == StResp);
        bus.resp_id    = id_q;
        bus.resp_res   = res_q;
        bus.resp_flags = flags_q;
        bus.resp_err   = err_q;
        bus.alu_op     = op_q;
        bus.alu_lhs    = lhs_q;
        bus.alu_rhs    = rhs_q;
    end

    // Operand capture on acceptance, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            lhs_q        <= '0;
            rhs_q        <= '0;
            res_q        <= '0;
            flags_q      <= '0;
            err_q        <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant_id;
            id_q         <= grant_id;
            op_q         <= sel_op;
            lhs_q        <= sel_lhs;
            rhs_q        <= sel_rhs;
            if (sel_illegal) begin
                res_q   <= '0;
                flags_q <= '0;
                err_q   <= 1'b1;
            end
        end else if (state_q == StExec) begin
            res_q   <= bus.alu_res;
            flags_q <= bus.alu_flags;
            err_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin (u_dut0) and fixed-priority (u_dut1) instances
// share the same stimulus; each has its own transaction-level reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, resp_rdy;
    logic [3:0]  op0, op1;
    logic [31:0] lhs0, rhs0, lhs1, rhs1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter_if if0 ();
    alu_arbiter_if if1 ();

    alu_arbiter #(.FIXED_PRIO(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    alu_arbiter #(.FIXED_PRIO(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Reference ALU: returns {N, Z, C, V, result}
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        w = '0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = a << b[4:0];
            4'h6: r = a >> b[4:0];
            4'h7: r = $signed(a) >>> b[4:0];
            4'h8: r = {31'b0, $signed(a) < $signed(b)};
            4'h9: r = {31'b0, a < b};
            4'hA: r = a * b;
            4'hB: r = b;
            default: r = '0;
        endcase
        return {r[31], r == 32'h0, c, v, r};
    endfunction

    assign {if0.alu_flags, if0.alu_res} = alu_fn(if0.alu_op, if0.alu_lhs, if0.alu_rhs);
    assign {if1.alu_flags, if1.alu_res} = alu_fn(if1.alu_op, if1.alu_lhs, if1.alu_rhs);

    assign if0.req0_valid = v0;   assign if1.req0_valid = v0;
    assign if0.req1_valid = v1;   assign if1.req1_valid = v1;
    assign if0.req0_op    = op0;  assign if1.req0_op    = op0;
    assign if0.req1_op    = op1;  assign if1.req1_op    = op1;
    assign if0.req0_lhs   = lhs0; assign if1.req0_lhs   = lhs0;
    assign if0.req0_rhs   = rhs0; assign if1.req0_rhs   = rhs0;
    assign if0.req1_lhs   = lhs1; assign if1.req1_lhs   = lhs1;
    assign if0.req1_rhs   = rhs1; assign if1.req1_rhs   = rhs1;
    assign if0.resp_ready = resp_rdy;
    assign if1.resp_ready = resp_rdy;

    // DUT outputs gathered into arrays indexed by instance
    logic        d_r0 [2], d_r1 [2], d_rv [2], d_id [2], d_err [2];
    logic [31:0] d_res [2], d_lhs [2], d_rhs [2];
    logic [3:0]  d_flags [2], d_op [2];
    always_comb begin
        d_r0[0] = if0.req0_ready;  d_r0[1] = if1.req0_ready;
        d_r1[0] = if0.req1_ready;  d_r1[1] = if1.req1_ready;
        d_rv[0] = if0.resp_valid;  d_rv[1] = if1.resp_valid;
        d_id[0] = if0.resp_id;     d_id[1] = if1.resp_id;
        d_err[0] = if0.resp_err;   d_err[1] = if1.resp_err;
        d_res[0] = if0.resp_res;   d_res[1] = if1.resp_res;
        d_flags[0] = if0.resp_flags; d_flags[1] = if1.resp_flags;
        d_op[0] = if0.alu_op;      d_op[1] = if1.alu_op;
        d_lhs[0] = if0.alu_lhs;    d_lhs[1] = if1.alu_lhs;
        d_rhs[0] = if0.alu_rhs;    d_rhs[1] = if1.alu_rhs;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one transaction at most, visible after a fixed delay
    bit          m_busy [2];
    bit          m_vis [2];
    int          m_wait [2];
    logic        m_last [2];
    logic        m_id [2];
    logic        m_err [2];
    logic [3:0]  m_op [2];
    logic [3:0]  m_flags [2];
    logic [31:0] m_lhs [2], m_rhs [2], m_res [2];

    // Compare every cycle, then advance the model across the coming clock edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("rst_ready0", d_r0[d], 1'b0);
                chk("rst_ready1", d_r1[d], 1'b0);
                chk("rst_resp_valid", d_rv[d], 1'b0);
                chk("rst_resp_fields", {d_id[d], d_err[d], d_flags[d], d_res[d]}, 64'h0);
                chk("rst_alu", {d_op[d], d_lhs[d], d_rhs[d]}, 64'h0);
                m_busy[d] = 0; m_vis[d] = 0; m_wait[d] = 0; m_last[d] = 1'b1;
                m_id[d] = 0; m_err[d] = 0; m_op[d] = 0; m_flags[d] = 0;
                m_lhs[d] = 0; m_rhs[d] = 0; m_res[d] = 0;
            end else begin
                logic        win_any, win, acc;
                logic [35:0] fr;
                win_any = v0 | v1;
                if (d == 1 || !(v0 && v1)) win = !v0;
                else win = !m_last[d];
                acc = win_any && !m_busy[d];
                chk("ready0", d_r0[d], acc && !win);
                chk("ready1", d_r1[d], acc && win);
                chk("resp_valid", d_rv[d], m_vis[d]);
                if (m_vis[d]) begin
                    chk("resp_id", d_id[d], m_id[d]);
                    chk("resp_res", d_res[d], m_res[d]);
                    chk("resp_flags", d_flags[d], m_flags[d]);
                    chk("resp_err", d_err[d], m_err[d]);
                end
                chk("alu_operands", {d_op[d], d_lhs[d], d_rhs[d]},
                    {m_op[d], m_lhs[d], m_rhs[d]});
                if (m_vis[d]) begin
                    if (resp_rdy) begin
                        m_busy[d] = 0;
                        m_vis[d] = 0;
                    end
                end else if (m_busy[d]) begin
                    m_wait[d]--;
                    if (m_wait[d] == 0) m_vis[d] = 1;
                end else if (acc) begin
                    m_busy[d] = 1;
                    m_last[d] = win;
                    m_id[d] = win;
                    m_op[d] = win ? op1 : op0;
                    m_lhs[d] = win ? lhs1 : lhs0;
                    m_rhs[d] = win ? rhs1 : rhs0;
                    if (m_op[d] > 4'hB) begin
                        m_res[d] = 0; m_flags[d] = 0; m_err[d] = 1; m_vis[d] = 1;
                    end else begin
                        fr = alu_fn(m_op[d], m_lhs[d], m_rhs[d]);
                        m_res[d] = fr[31:0]; m_flags[d] = fr[35:32]; m_err[d] = 0;
                        m_wait[d] = 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic q0 [$];
    logic q1 [$];
    int   r1_cnt;
    bit   seen;

    initial begin
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1; resp_rdy = 1'b0;
        op0 = 4'h3; op1 = 4'h4;
        lhs0 = 32'h1234; rhs0 = 32'h5678; lhs1 = 32'h9; rhs1 = 32'hA;
        step();
        step();
        // Ready must stay low during reset even with both requesters valid
        @(negedge clk);
        chk("lit_rst_ready", {if0.req0_ready, if0.req1_ready, if1.req0_ready}, 3'b000);
        chk("lit_rst_last_grant_alu", if0.alu_op, 4'h0);

        // Signed-overflow add from requester 0
        step();
        rst_n = 1'b1; v1 = 1'b0; resp_rdy = 1'b1;
        op0 = 4'h0; lhs0 = 32'h7FFF_FFFF; rhs0 = 32'h1;
        @(negedge clk);
        chk("lit_add_ready0", if0.req0_ready, 1'b1);
        step();
        v0 = 1'b0;
        @(negedge clk);
        chk("lit_add_exec_no_resp", {if0.resp_valid, if0.req0_ready}, 2'b00);
        chk("lit_add_alu_lhs", if0.alu_lhs, 32'h7FFF_FFFF);
        step();
        @(negedge clk);
        chk("lit_add_resp_valid", if0.resp_valid, 1'b1);
        chk("lit_add_resp_id", if0.resp_id, 1'b0);
        chk("lit_add_resp_res", if0.resp_res, 32'h8000_0000);
        chk("lit_add_resp_flags", if0.resp_flags, 4'h9);
        chk("lit_add_resp_err", if0.resp_err, 1'b0);

        // Illegal opcode from requester 1 answers one cycle after acceptance
        step();
        v1 = 1'b1; op1 = 4'hE; lhs1 = 32'hDEAD; rhs1 = 32'hBEEF;
        @(negedge clk);
        chk("lit_ill_ready1", {if0.req1_ready, if1.req1_ready}, 2'b11);
        step();
        v1 = 1'b0;
        @(negedge clk);
        chk("lit_ill_resp", {if0.resp_valid, if0.resp_id, if0.resp_err}, 3'b111);
        chk("lit_ill_res_flags", {if0.resp_flags, if0.resp_res}, 36'h0);
        step();

        // Round robin vs fixed priority with both requesters valid continuously
        reset_pulse();
        v0 = 1'b1; v1 = 1'b1; op0 = 4'h2; op1 = 4'h3; resp_rdy = 1'b1;
        r1_cnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (if0.resp_valid) q0.push_back(if0.resp_id);
            if (if1.resp_valid) q1.push_back(if1.resp_id);
            if (if1.req1_ready) r1_cnt++;
        end
        chk("lit_rr_count", q0.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < q0.size(); i++) chk("lit_rr_id", q0[i], i[0]);
        chk("lit_fixed_count", q1.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < q1.size(); i++) chk("lit_fixed_id", q1[i], 1'b0);
        chk("lit_fixed_no_ready1", r1_cnt, 0);

        // Consumer back-pressure holds the response and blocks new requests
        step();
        reset_pulse();
        resp_rdy = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = if0.resp_valid;
        end
        chk("lit_stall_resp_seen", seen, 1'b1);
        repeat (5) begin
            step();
            @(negedge clk);
            chk("lit_stall_no_ready", {if0.req0_ready, if0.req1_ready}, 2'b00);
            chk("lit_stall_resp_held", {if0.resp_valid, if0.resp_id}, 2'b10);
        end
        step();
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("lit_stall_hs_cycle_no_ready", {if0.req0_ready, if0.req1_ready}, 2'b00);
        step();
        @(negedge clk);
        chk("lit_stall_next_accept", {if0.req0_ready, if0.req1_ready}, 2'b01);

        // Asynchronous reset during EXEC discards the operation
        step();
        reset_pulse();
        v1 = 1'b0; op0 = 4'h4; lhs0 = 32'hA5A5_0001; rhs0 = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("lit_rexec_ready0", if0.req0_ready, 1'b1);
        step();
        v0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_rexec_async", {if0.resp_valid, if0.alu_op, if0.alu_lhs}, 37'h0);
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | if0.resp_valid | if1.resp_valid;
        end
        chk("lit_rexec_no_resp", seen, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            v0 = ($urandom_range(0, 9) < 6);
            v1 = ($urandom_range(0, 9) < 6);
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 15));
            lhs0 = rand_word(); rhs0 = rand_word();
            lhs1 = rand_word(); rhs1 = rand_word();
            resp_rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
            end
        end
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  operation accepted this cycle.
REQ-006 req0_op / req1_op  input  4  ALU opcode, legal range 4'h0..4'hB.
REQ-007 req0_lhs, req0_rhs / req1_lhs, req1_rhs  input  32  operands.
REQ-008 alu_op  output  4  opcode to the shared combinational ALU.
REQ-009 alu_lhs, alu_rhs  output  32  operands to the ALU.
REQ-010 alu_res  input  32  ALU result.
REQ-011 alu_flags  input  4  ALU flags, passed through unmodified.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_id  output  1  requester owning the response (0 or 1).
REQ-014 resp_res  output  32  captured result.
REQ-015 resp_flags  output  4  captured flags.
REQ-016 resp_err  output  1  1 = illegal opcode, operation not executed.
REQ-017 resp_ready  input  1  consumer accepts the response.

Function
REQ-018 FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-019 IDLE: reqN_ready SHALL be asserted combinationally for the granted requester only, only while in IDLE with that reqN_valid high; both readys never high together.
REQ-020 Arbitration, FIXED_PRIO=0: one valid requester wins; both valid -> the one not granted last; last_grant updates only on acceptance.
REQ-021 Arbitration, FIXED_PRIO=1: requester 0 wins whenever req0_valid is high.
REQ-022 On acceptance: op, lhs, rhs and grant id registered; legal op -> EXEC; illegal op (4'hC..4'hF) -> RESP with resp_err=1, resp_res=0, resp_flags=0, ALU not sampled.
REQ-023 alu_op/alu_lhs/alu_rhs SHALL be driven from the operand registers at all times (stable through EXEC).
REQ-024 EXEC lasts exactly one cycle: alu_res and alu_flags captured into response registers at its end, resp_err=0, -> RESP.
REQ-025 RESP: resp_valid=1, resp_id/res/flags/err held stable until resp_ready sampled high; then -> IDLE.
REQ-026 Latency: acceptance at edge N -> resp_valid high after edge N+2 (legal op) or N+1 (illegal op).
REQ-027 resp_ready high while resp_valid is low SHALL be ignored.
REQ-028 No new request accepted in EXEC or RESP; earliest next acceptance is the cycle after the response handshake (min 3 cycles per legal op).
REQ-029 Requests changing or deasserting while not ready SHALL have no effect.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, req0_ready=req1_ready=0, resp_valid=0, resp_id=0, resp_res=0, resp_flags=0, resp_err=0, operand registers (and alu_* outputs) = 0, last_grant=1 (requester 0 wins first).
REQ-031 Reset during EXEC or RESP SHALL discard the in-flight operation; no response emitted after release.
REQ-032 ready SHALL stay 0 while rst_n is low, regardless of reqN_valid.

Verification
REQ-033 req0: op=4'h0, lhs=32'h7FFF_FFFF, rhs=1, resp_ready=1 -> req0_ready 1 cycle, 2 cycles later resp_valid=1, resp_id=0, resp_res=32'h8000_0000, resp_flags=alu_flags (overflow bit 0 set), resp_err=0.
REQ-034 Both valid continuously, FIXED_PRIO=0, after reset -> grants 0,1,0,1; resp_id sequence matches.
REQ-035 Both valid, FIXED_PRIO=1 -> requester 0 granted every time; req1_ready never asserted.
REQ-036 req1 op=4'hE -> resp_err=1, resp_res=0, resp_flags=0, resp_id=1, resp_valid one cycle after acceptance.
REQ-037 resp_ready held 0 for 5 cycles -> resp fields stable, no readys, new request accepted only cycle after resp_ready=1.
REQ-038 rst_n pulsed low during EXEC -> all outputs to reset values asynchronously; no resp_valid after release until a new acceptance.
